// File: rtl/transfer_sender_pkg.sv
// rtl/transfer_sender_pkg.sv - shared command codes, slot constants and state encoding for transfer_sender
package transfer_sender_pkg;

    localparam int SLOT_BITS = 8;

    localparam logic [7:0] CMD_RESET  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h04;
    localparam logic [7:0] CMD_ERASE  = 8'h05;
    localparam logic [7:0] CMD_CONFIG = 8'h06;
    localparam logic [7:0] CMD_BINARY = 8'h07;
    localparam logic [7:0] CMD_SYNC   = 8'h08;

    localparam logic [7:0] IDLE_BYTE  = 8'h00;

    // Slot kinds: idle fill, normal popped byte, data byte paired behind CMD_BINARY
    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_PAIR = 2'd2;

    typedef enum logic [1:0] {
        STATE_FILL = ST_FILL,
        STATE_SEND = ST_SEND,
        STATE_PAIR = ST_PAIR
    } state_e;

    function automatic logic is_binary_cmd(input logic [7:0] b);
        return b == CMD_BINARY;
    endfunction

    // A binary command may only leave the queue together with its data byte
    function automatic logic head_may_pop(input logic [7:0] head, input logic [3:0] count);
        return !is_binary_cmd(head) || (count >= 4'd2);
    endfunction

endpackage

// File: rtl/transfer_fifo.sv
// rtl/transfer_fifo.sv - small byte FIFO with registered occupancy and combinational head
module transfer_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [3:0]       count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; the caller never writes when full or reads when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/transfer_sender.sv
// rtl/transfer_sender.sv - serialises queued bytes into continuous 8-bit slots (TRANSFER_SENDER_FIFO_EN selects DEPTH 8)
module transfer_sender
    import transfer_sender_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       readyForTransferIn,
    input  logic       wrValid,
    input  logic [7:0] wrByte,
    output logic       wrReady,
    output logic       dataOut,
    output logic       slotStart,
    output logic       sentValid,
    output logic [3:0] fifoCount
);

`ifdef TRANSFER_SENDER_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 2;
`endif

    localparam logic [2:0] LAST_BIT = 3'(SLOT_BITS - 1);

    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] slot_byte;
    logic [1:0] state;
    logic [1:0] next_state;
    logic [7:0] head;
    logic [7:0] next_byte;
    logic       boundary;
    logic       pair_pending;
    logic       pop;
    logic       rd_en;
    logic       wr_accept;

    assign boundary     = (bit_cnt == LAST_BIT);
    assign pair_pending = (state == ST_SEND) && is_binary_cmd(slot_byte);
    assign wrReady      = !rst && (fifoCount < 4'(DEPTH));
    assign wr_accept    = wrValid && wrReady;
    assign rd_en        = boundary && pop;
    assign next_byte    = pop ? head : IDLE_BYTE;

    transfer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_data (wrByte),
        .rd_en   (rd_en),
        .rd_data (head),
        .count   (fifoCount)
    );

    // Choose what the next slot carries: forced pair data, a permitted head byte, or idle fill
    always_comb begin
        pop        = 1'b0;
        next_state = ST_FILL;
        if (pair_pending) begin
            pop        = 1'b1;
            next_state = ST_PAIR;
        end else if ((fifoCount != 4'd0) && readyForTransferIn && head_may_pop(head, fifoCount)) begin
            pop        = 1'b1;
            next_state = ST_SEND;
        end
    end

    // Bit counter and MSB-first shifter; a new slot byte is loaded on the edge where the counter is 7
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            slot_byte <= IDLE_BYTE;
            state     <= ST_FILL;
            dataOut   <= 1'b0;
            slotStart <= 1'b0;
            sentValid <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            slotStart <= boundary;
            if (boundary) begin
                state     <= next_state;
                slot_byte <= next_byte;
                dataOut   <= next_byte[7];
                shift_reg <= {next_byte[6:0], 1'b0};
                sentValid <= pop;
            end else begin
                dataOut   <= shift_reg[7];
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_transfer_sender.sv
// tb/tb_transfer_sender.sv - self-checking bench for transfer_sender
module tb_transfer_sender;
    import transfer_sender_pkg::*;

`ifdef TRANSFER_SENDER_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       readyForTransferIn = 1'b0;
    logic       wrValid = 1'b0;
    logic [7:0] wrByte = 8'h00;
    logic       wrReady;
    logic       dataOut;
    logic       slotStart;
    logic       sentValid;
    logic [3:0] fifoCount;

    transfer_sender dut (
        .clk                (clk),
        .rst                (rst),
        .readyForTransferIn (readyForTransferIn),
        .wrValid            (wrValid),
        .wrByte             (wrByte),
        .wrReady            (wrReady),
        .dataOut            (dataOut),
        .slotStart          (slotStart),
        .sentValid          (sentValid),
        .fifoCount          (fifoCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of pending bytes and the slot currently on the wire
    byte unsigned q[$];
    int           m_pos;
    logic [7:0]   m_byte;
    logic         m_valid;
    logic         m_start;
    logic         m_pair;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pos   = 0;
        m_byte  = 8'h00;
        m_valid = 1'b0;
        m_start = 1'b0;
        m_pair  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] b, input logic r);
        logic acc;
        acc = v && (q.size() < DEPTH);
        if (m_pos == 7) begin
            if (m_pair) begin
                m_byte  = q.pop_front();
                m_valid = 1'b1;
                m_pair  = 1'b0;
            end else if (q.size() > 0 && r && (q[0] != 8'h07 || q.size() >= 2)) begin
                m_byte  = q.pop_front();
                m_valid = 1'b1;
                m_pair  = (m_byte == 8'h07);
            end else begin
                m_byte  = 8'h00;
                m_valid = 1'b0;
            end
            m_pos   = 0;
            m_start = 1'b1;
        end else begin
            m_pos   = m_pos + 1;
            m_start = 1'b0;
        end
        if (acc) q.push_back(b);
    endtask

    task automatic check_outputs();
        chk("dataOut",   int'(dataOut),   int'(m_byte[3'(7 - m_pos)]));
        chk("slotStart", int'(slotStart), int'(m_start));
        chk("sentValid", int'(sentValid), int'(m_valid));
        chk("fifoCount", int'(fifoCount), q.size());
        chk("wrReady",   int'(wrReady),   (q.size() < DEPTH) ? 1 : 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " dataOut"},   int'(dataOut),   0);
        chk({tag, " slotStart"}, int'(slotStart), 0);
        chk({tag, " sentValid"}, int'(sentValid), 0);
        chk({tag, " fifoCount"}, int'(fifoCount), 0);
        chk({tag, " wrReady"},   int'(wrReady),   0);
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic r);
        wrValid            = v;
        wrByte             = b;
        readyForTransferIn = r;
        @(posedge clk);
        model_edge(v, b, r);
        #1;
        check_outputs();
    endtask

    // Asserted mid-cycle so the asynchronous clear is visible before any edge
    task automatic do_reset();
        #2;
        rst                = 1'b1;
        wrValid            = 1'b0;
        readyForTransferIn = 1'b0;
        #1;
        model_reset();
        check_reset("reset async");
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset held");
        rst = 1'b0;
    endtask

    // Runs up to the next slot boundary, then captures that whole slot
    task automatic get_slot(input logic r, output logic [7:0] data, output logic vld);
        int n;
        n    = 7 - m_pos;
        data = 8'h00;
        vld  = 1'b0;
        repeat (n) step(1'b0, 8'h00, r);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, r);
            data = {data[6:0], dataOut};
            vld  = vld | sentValid;
        end
    endtask

    typedef struct {
        logic [7:0] wr;
        logic       rdy;
        logic [7:0] exp_bits;
        logic       exp_vld;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic       gv;
        int         starts;
        int         ones;
        int         svs;

        tbl[0] = '{8'h03, 1'b1, 8'b0000_0011, 1'b1, 0};
        tbl[1] = '{8'hA5, 1'b1, 8'b1010_0101, 1'b1, 0};
        tbl[2] = '{8'h07, 1'b1, 8'b0000_0000, 1'b0, 1};
        tbl[3] = '{8'h80, 1'b0, 8'b0000_0000, 1'b0, 1};
        tbl[4] = '{8'hFF, 1'b1, 8'b1111_1111, 1'b1, 0};

        model_reset();
        do_reset();

        starts = 0; ones = 0; svs = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'h00, 1'b1);
            starts += int'(slotStart);
            ones   += int'(dataOut);
            svs    += int'(sentValid);
        end
        chk("idle slotStart pulses", starts, 5);
        chk("idle dataOut ones", ones, 0);
        chk("idle sentValid cycles", svs, 0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            step(1'b1, tbl[i].wr, tbl[i].rdy);
            get_slot(tbl[i].rdy, got, gv);
            chk($sformatf("vec%0d bits", i), int'(got), int'(tbl[i].exp_bits));
            chk($sformatf("vec%0d valid", i), int'(gv), int'(tbl[i].exp_vld));
            chk($sformatf("vec%0d count", i), int'(fifoCount), tbl[i].exp_cnt);
        end

        do_reset();
        step(1'b1, 8'h07, 1'b1);
        for (int i = 0; i < 3; i++) begin
            get_slot(1'b1, got, gv);
            chk($sformatf("lone cmd withheld slot%0d", i), int'(gv), 0);
        end
        step(1'b1, 8'hA5, 1'b1);
        get_slot(1'b1, got, gv);
        chk("pair cmd byte", int'(got), 8'h07);
        chk("pair cmd valid", int'(gv), 1);
        get_slot(1'b1, got, gv);
        chk("pair data byte", int'(got), 8'hA5);
        chk("pair data valid", int'(gv), 1);

        do_reset();
        step(1'b1, 8'h07, 1'b1);
        step(1'b1, 8'h5C, 1'b1);
        get_slot(1'b1, got, gv);
        chk("forced cmd byte", int'(got), 8'h07);
        get_slot(1'b0, got, gv);
        chk("forced data byte", int'(got), 8'h5C);
        chk("forced data valid", int'(gv), 1);
        step(1'b1, 8'h11, 1'b0);
        get_slot(1'b0, got, gv);
        chk("held after pair valid", int'(gv), 0);
        chk("held after pair count", int'(fifoCount), 1);
        get_slot(1'b1, got, gv);
        chk("released byte", int'(got), 8'h11);

        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        chk("full wrReady", int'(wrReady), 0);
        step(1'b1, 8'hEE, 1'b0);
        chk("full rejects write", int'(fifoCount), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            get_slot(1'b1, got, gv);
            chk($sformatf("drain byte%0d", i), int'(got), 8'h10 + i);
            chk($sformatf("drain valid%0d", i), int'(gv), 1);
        end
        chk("drained count", int'(fifoCount), 0);

        do_reset();
        step(1'b1, 8'h07, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        get_slot(1'b1, got, gv);
        chk("pre-abort cmd", int'(got), 8'h07);
        repeat (5) step(1'b0, 8'h00, 1'b1);
        chk("abort point bit", m_pos, 4);
        do_reset();
        get_slot(1'b1, got, gv);
        chk("post-abort slot byte", int'(got), 8'h00);
        chk("post-abort slot valid", int'(gv), 0);
        chk("post-abort count", int'(fifoCount), 0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic [7:0] b;
            logic       r;
            if (i == 1500) do_reset();
            v = ($urandom_range(0, 2) != 0);
            b = ($urandom_range(0, 3) == 0) ? 8'h07 : 8'($urandom);
            r = ($urandom_range(0, 3) != 0);
            step(v, b, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
